// File: rtl/clkmgr_lock_monitor_pkg.sv
// Shared definitions for the clock-manager lock monitor: state encodings and widths.
package clkmgr_lock_monitor_pkg;

  typedef enum logic [2:0] {
    RESET_PULSE = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RUN         = 3'd3,
    FAIL        = 3'd4
  } state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clkmgr_lock_monitor_if.sv
// Status/control bundle between the lock monitor and the clock manager / user logic.
interface clkmgr_lock_monitor_if;
  import clkmgr_lock_monitor_pkg::*;

  logic                  locked;
  logic                  dcm_rst;
  logic                  reset_out;
  logic                  ready;
  logic                  fail;
  logic [2:0]            state;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  // master: the monitor itself; slave: clock manager and user-logic side
  modport master (
    input  locked,
    output dcm_rst, reset_out, ready, fail, state, loss_cnt
  );

  modport slave (
    output locked,
    input  dcm_rst, reset_out, ready, fail, state, loss_cnt
  );

endinterface

// File: rtl/clkmgr_sync2.sv
// Two-flop synchronizer for asynchronous status inputs, async active-high reset.
module clkmgr_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/clkmgr_lock_monitor.sv
// Lock supervisor / reset sequencer for the clock manager.
// Define CLKMGR_MON_STATS_EN to build the saturating lock-loss counter.
module clkmgr_lock_monitor
  import clkmgr_lock_monitor_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 125000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRY           = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  clkmgr_lock_monitor_if.master mon
);

  localparam int unsigned CNT_W =
      $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES) + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RST_PULSE_CYCLES - 1);

  logic               w_lock_s;
  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [RETRY_W-1:0] r_retry, w_retry_d;
  logic               r_dcm_rst, r_reset_out, r_ready, r_fail;

  clkmgr_sync2 u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (mon.locked),
    .o_q   (w_lock_s)
  );

  // Counter holds cycles-remaining-minus-one, so a state exits on the edge it reads zero
  function automatic logic [CNT_W-1:0] load_val(input state_e s);
    case (s)
      RESET_PULSE: return CNT_W'(RST_PULSE_CYCLES - 1);
      WAIT_LOCK:   return CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
      STABLE:      return CNT_W'(STABLE_CYCLES - 1);
      default:     return '0;
    endcase
  endfunction

  always_comb begin
    w_state_d = r_state;
    w_retry_d = r_retry;
    case (r_state)
      RESET_PULSE: begin
        if (r_cnt == '0) w_state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout
        if (w_lock_s) begin
          w_state_d = STABLE;
        end else if (r_cnt == '0) begin
          w_retry_d = r_retry + 1'b1;
          if ((MAX_RETRY != 0) && (w_retry_d == RETRY_W'(MAX_RETRY))) w_state_d = FAIL;
          else                                                       w_state_d = RESET_PULSE;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_d = WAIT_LOCK;
        end else if (r_cnt == '0) begin
          w_state_d = RUN;
          w_retry_d = '0;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_d = RESET_PULSE;
          w_retry_d = '0;
        end
      end
      FAIL:    w_state_d = FAIL;
      default: w_state_d = RESET_PULSE;
    endcase

    if (w_state_d != r_state) w_cnt_d = load_val(w_state_d);
    else if (r_cnt != '0)     w_cnt_d = r_cnt - 1'b1;
    else                      w_cnt_d = r_cnt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RESET_PULSE;
      r_cnt       <= CNT_RST;
      r_retry     <= '0;
      r_dcm_rst   <= 1'b1;
      r_reset_out <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_retry     <= w_retry_d;
      r_dcm_rst   <= (w_state_d == RESET_PULSE) || (w_state_d == FAIL);
      r_reset_out <= (w_state_d != RUN);
      r_ready     <= (w_state_d == RUN);
      r_fail      <= (w_state_d == FAIL);
    end
  end

  assign mon.dcm_rst   = r_dcm_rst;
  assign mon.reset_out = r_reset_out;
  assign mon.ready     = r_ready;
  assign mon.fail      = r_fail;
  assign mon.state     = r_state;

`ifdef CLKMGR_MON_STATS_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_loss_cnt <= '0;
    end else if ((r_state == RUN) && !w_lock_s && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign mon.loss_cnt = r_loss_cnt;
`else
  assign mon.loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clkmgr_lock_monitor.sv
// Self-checking bench for clkmgr_lock_monitor: vector table with scoreboard plus corner sequences.
module tb_clkmgr_lock_monitor;
  import clkmgr_lock_monitor_pkg::*;

  localparam int unsigned P = 4;
  localparam int unsigned T = 20;
  localparam int unsigned S = 8;
  localparam int unsigned R = 3;

`ifdef CLKMGR_MON_STATS_EN
  localparam logic [7:0] L1  = 8'd1;
  localparam logic [7:0] SAT = 8'd255;
`else
  localparam logic [7:0] L1  = 8'd0;
  localparam logic [7:0] SAT = 8'd0;
`endif

  typedef struct {
    bit         rst_first;
    logic       locked;
    int         ticks;
    logic       dcm;
    logic       ro;
    logic       rdy;
    logic       fl;
    logic [2:0] st;
    logic [7:0] loss;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  vec_t        vecs[$];
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  clkmgr_lock_monitor_if mon_if ();

  clkmgr_lock_monitor #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .STABLE_CYCLES       (S),
    .MAX_RETRY           (R)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mon   (mon_if)
  );

  function automatic vec_t mk(bit r, logic l, int t, logic d, logic ro, logic rd, logic f,
                              logic [2:0] st, logic [7:0] lc);
    vec_t v;
    v.rst_first = r; v.locked = l; v.ticks = t;
    v.dcm = d; v.ro = ro; v.rdy = rd; v.fl = f; v.st = st; v.loss = lc;
    return v;
  endfunction

  function automatic logic [14:0] sample();
    return {mon_if.dcm_rst, mon_if.reset_out, mon_if.ready, mon_if.fail, mon_if.state,
            mon_if.loss_cnt};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = sample();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {dcm,ro,rdy,fail,st,loss}=%h required %h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (mon_if.state !== st && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (mon_if.state !== st) begin
      bad++;
      $display("FAIL %s: state=%0d required %0d within %0d cycles", name, mon_if.state, st,
               budget);
    end
  endtask

  // Reset is released right after an edge; that edge is cycle 0 of the following vectors
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_if.locked = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    mon_if.locked = 1'b0;
    tick(2);
    check("reset_state", {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});

    // Normal bring-up, lock raised 10 cycles after reset release
    vecs.push_back(mk(1, 0, 3, 1, 1, 0, 0, RESET_PULSE, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 0, 6, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, RUN, 0));
    // Lock loss in RUN, then re-lock
    vecs.push_back(mk(0, 1, 5, 0, 0, 1, 0, RUN, 0));
    vecs.push_back(mk(0, 0, 2, 0, 0, 1, 0, RUN, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, RESET_PULSE, L1));
    vecs.push_back(mk(0, 0, 3, 1, 1, 0, 0, RESET_PULSE, L1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, WAIT_LOCK, L1));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0, WAIT_LOCK, L1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, STABLE, L1));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0, STABLE, L1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, RUN, L1));
    // Two-cycle glitch during STABLE
    vecs.push_back(mk(1, 0, 10, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 1, 4, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 0, 2, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, RUN, 0));
    // Retry exhaustion with lock never asserted
    vecs.push_back(mk(1, 0, 3, 1, 1, 0, 0, RESET_PULSE, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 0, 19, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, RESET_PULSE, 0));
    vecs.push_back(mk(0, 0, 3, 1, 1, 0, 0, RESET_PULSE, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 0, 20, 1, 1, 0, 0, RESET_PULSE, 0));
    vecs.push_back(mk(0, 0, 4, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 0, 19, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, FAIL, 0));
    vecs.push_back(mk(0, 1, 30, 1, 1, 0, 1, FAIL, 0));
    // lock_s rises on the final WAIT_LOCK cycle
    vecs.push_back(mk(1, 0, 21, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0, WAIT_LOCK, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0, STABLE, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, RUN, 0));

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.rst_first) apply_reset();
      mon_if.locked = v.locked;
      exp_q.push_back({v.dcm, v.ro, v.rdy, v.fl, v.st, v.loss});
      tick(v.ticks);
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // Force 260 lock losses to exercise counter saturation
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      mon_if.locked = 1'b1;
      wait_state(RUN, 60, $sformatf("sat_run%0d", i));
      mon_if.locked = 1'b0;
      wait_state(RESET_PULSE, 10, $sformatf("sat_loss%0d", i));
    end
    mon_if.locked = 1'b1;
    wait_state(RUN, 60, "sat_final_run");
    total++;
    if (mon_if.loss_cnt !== SAT) begin
      bad++;
      $display("FAIL loss_sat: got %0d required %0d", mon_if.loss_cnt, SAT);
    end

    // Asynchronous reset in the middle of a cycle while in RUN
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_run_rst", {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});
    tick(2);
    rst = 1'b0;
    mon_if.locked = 1'b0;
    tick(3);
    check("post_rst_pulse", {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
